// File: rtl/tc_fetch_pkg.sv
// Shared widths and types for the program fetch sequencer.
// Pure declarations, no logic.
// Default word size is 4 bytes with a 16-bit byte address space.
package tc_fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam int DEF_BYTES_PER_INSTR = 4;

  // Fetch PC / byte address into the program ROM.
  typedef logic [ADDR_W-1:0] fetch_pc_t;

  // Instruction word at the default width; byte k sits at bits [8k+7:8k].
  typedef logic [DEF_BYTES_PER_INSTR*BYTE_W-1:0] instr_word_t;

endpackage

// File: rtl/tc_program_fetch_sequencer_if.sv
// Fetch sequencer bundle: ROM port, instruction handshake, redirect/halt controls.
// master = the sequencer, slave = the ROM/decode/control side around it.
// Word width follows BYTES_PER_INSTR.
interface tc_program_fetch_sequencer_if #(
  parameter int BYTES_PER_INSTR = tc_fetch_pkg::DEF_BYTES_PER_INSTR
) ();
  import tc_fetch_pkg::*;

  fetch_pc_t                             mem_address;
  logic [BYTE_W-1:0]                     mem_data;
  logic [BYTES_PER_INSTR*BYTE_W-1:0]     instr_out;
  fetch_pc_t                             instr_pc;
  logic                                  instr_valid;
  logic                                  instr_ready;
  logic                                  jump_en;
  fetch_pc_t                             jump_target;
  logic                                  halt;
  logic                                  busy;

  modport master (
    output mem_address,
    input  mem_data,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  jump_en,
    input  jump_target,
    input  halt,
    output busy
  );

  modport slave (
    input  mem_address,
    output mem_data,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output jump_en,
    output jump_target,
    output halt,
    input  busy
  );

endinterface

// File: rtl/tc_fetch_assembler.sv
// Collects ROM bytes into one instruction word and remembers the address of byte 0.
// Latency: a written byte is visible in word/count on the next cycle.
// Backpressure: none internally; the caller must not write while full and drains with rd_en.
module tc_fetch_assembler
  import tc_fetch_pkg::*;
#(
  parameter int BYTES_PER_INSTR = DEF_BYTES_PER_INSTR,
  localparam int CNT_W = $clog2(BYTES_PER_INSTR + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              wr_en,
  input  logic [BYTE_W-1:0]                 wr_dat,
  input  fetch_pc_t                         wr_pc,
  input  logic                              rd_en,
  output logic [CNT_W-1:0]                  count,
  output logic                              full,
  output logic [BYTES_PER_INSTR*BYTE_W-1:0] word,
  output fetch_pc_t                         word_pc
);

  assign full = (count == CNT_W'(BYTES_PER_INSTR));

  // Byte-indexed fill; flush and drain both empty the register, flush wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      word    <= '0;
      word_pc <= '0;
    end else if (flush || rd_en) begin
      count <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BYTES_PER_INSTR; k++) begin
        if (count == CNT_W'(k)) begin
          word[k*BYTE_W +: BYTE_W] <= wr_dat;
        end
      end
      if (count == '0) begin
        word_pc <= wr_pc;
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tc_program_fetch_sequencer.sv
// Drives the program ROM address stream and packs returned bytes into instruction words.
// Latency: ROM read 1 cycle, then one cycle from last captured byte to instr_valid.
// Backpressure: issue stops when assembled + in-flight bytes fill a word; one word held in output, one in assembly.
module tc_program_fetch_sequencer
  import tc_fetch_pkg::*;
#(
  parameter int        BYTES_PER_INSTR = DEF_BYTES_PER_INSTR,
  parameter fetch_pc_t RESET_PC        = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  tc_program_fetch_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(BYTES_PER_INSTR + 1);

  fetch_pc_t                         fetch_pc;
  logic                              inflight;
  logic                              issue;
  logic                              capture;
  logic                              transfer;

  logic [CNT_W-1:0]                  asm_count;
  logic                              asm_full;
  logic [BYTES_PER_INSTR*BYTE_W-1:0] asm_word;
  fetch_pc_t                         asm_pc;

  logic [BYTES_PER_INSTR*BYTE_W-1:0] out_word;
  fetch_pc_t                         out_pc;
  logic                              out_valid;

  // Only issue when the byte can be guaranteed a slot in the assembly register.
  assign issue    = !rst && !bus.halt && !bus.jump_en &&
                    ((int'(asm_count) + int'(inflight)) < BYTES_PER_INSTR);
  // A jump discards the byte returning this cycle.
  assign capture  = inflight && !bus.jump_en;
  assign transfer = asm_full && (!out_valid || bus.instr_ready) && !bus.jump_en;

  assign bus.mem_address = fetch_pc;
  assign bus.instr_out   = out_word;
  assign bus.instr_pc    = out_pc;
  assign bus.instr_valid = out_valid;
  assign bus.busy        = inflight || (asm_count != '0);

  // Fetch PC and in-flight tracking; jump redirects, halt just freezes the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (bus.jump_en) begin
        fetch_pc <= bus.jump_target;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 16'd1;
      end
    end
  end

  // The returning byte belongs to the address issued last cycle, which is fetch_pc - 1
  // because the PC only advances on issue and a jump kills the in-flight byte.
  tc_fetch_assembler #(
    .BYTES_PER_INSTR (BYTES_PER_INSTR)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.jump_en),
    .wr_en   (capture),
    .wr_dat  (bus.mem_data),
    .wr_pc   (fetch_pc - 16'd1),
    .rd_en   (transfer),
    .count   (asm_count),
    .full    (asm_full),
    .word    (asm_word),
    .word_pc (asm_pc)
  );

  // Output register and valid/ready handshake; jump clears valid ahead of any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_pc    <= '0;
    end else if (bus.jump_en) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_word  <= asm_word;
      out_pc    <= asm_pc;
      out_valid <= 1'b1;
    end else if (out_valid && bus.instr_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_program_fetch_sequencer.sv
// Directed bench for the fetch sequencer with a registered ROM model.
// ROM byte at address a is a[7:0] ^ a[15:8].
// Outputs are sampled 1 time unit after each rising edge.
module tb_tc_program_fetch_sequencer;
  import tc_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  tc_program_fetch_sequencer_if #(.BYTES_PER_INSTR(4)) bus ();

  tc_program_fetch_sequencer #(
    .BYTES_PER_INSTR (4),
    .RESET_PC        (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Registered ROM, output forced to zero during reset.
  always @(posedge clk) begin
    if (rst) bus.mem_data <= 8'h00;
    else     bus.mem_data <= rom_byte(bus.mem_address);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Steps until instr_valid is seen (bounded); n returns the number of cycles stepped.
  task automatic wait_word(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.instr_valid && n < 200);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump_en     = 1'b0;
    bus.jump_target = 16'h0000;
    bus.halt        = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_addr",  32'(bus.mem_address), 32'h0000);
    chk("rst_out",   bus.instr_out,        32'h0);
    chk("rst_pc",    32'(bus.instr_pc),    32'h0);

    // Streaming: first word is valid after edge 5 counting from the first edge with rst low.
    rst = 1'b0;
    repeat (5) step();
    chk("e4_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("e5_valid", 32'(bus.instr_valid), 32'd1);
    chk("e5_out",   bus.instr_out,        32'h03020100);
    chk("e5_pc",    32'(bus.instr_pc),    32'h0000);
    wait_word("w1", n);
    chk("w1_out", bus.instr_out,     32'h07060504);
    chk("w1_pc",  32'(bus.instr_pc), 32'h0004);

    // Backpressure: hold the first word for 20 cycles.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    wait_word("s0", n);
    chk("s0_out", bus.instr_out, 32'h03020100);
    bus.instr_ready = 1'b0;
    repeat (20) step();
    chk("stall_addr",  32'(bus.mem_address), 32'h0008);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_out",   bus.instr_out,        32'h03020100);
    chk("stall_pc",    32'(bus.instr_pc),    32'h0000);
    bus.instr_ready = 1'b1;
    step();
    chk("rel_valid", 32'(bus.instr_valid), 32'd1);
    chk("rel_out",   bus.instr_out,        32'h07060504);
    chk("rel_pc",    32'(bus.instr_pc),    32'h0004);
    wait_word("s2", n);
    chk("s2_out", bus.instr_out,     32'h0B0A0908);
    chk("s2_pc",  32'(bus.instr_pc), 32'h0008);

    // Jump with two bytes already assembled for the word at 0x000C.
    repeat (3) step();
    bus.jump_en     = 1'b1;
    bus.jump_target = 16'h0100;
    step();
    bus.jump_en = 1'b0;
    chk("jmp_addr",  32'(bus.mem_address), 32'h0100);
    chk("jmp_valid", 32'(bus.instr_valid), 32'd0);
    wait_word("j1", n);
    chk("j1_out", bus.instr_out,     32'h02030001);
    chk("j1_pc",  32'(bus.instr_pc), 32'h0100);

    // Jump in the same cycle the 0x0100 word is handed over; also exercises address wrap.
    bus.jump_en     = 1'b1;
    bus.jump_target = 16'hFFFE;
    step();
    bus.jump_en = 1'b0;
    chk("hsj_valid", 32'(bus.instr_valid), 32'd0);
    chk("hsj_addr",  32'(bus.mem_address), 32'hFFFE);
    wait_word("wrap", n);
    chk("wrap_out", bus.instr_out,     32'h01000001);
    chk("wrap_pc",  32'(bus.instr_pc), 32'hFFFE);

    // Halt for 3 cycles mid-word: addresses 2,3 issued, then frozen at 4.
    repeat (2) step();
    bus.halt = 1'b1;
    repeat (3) step();
    bus.halt = 1'b0;
    chk("halt_addr", 32'(bus.mem_address), 32'h0004);
    wait_word("halt", n);
    chk("halt_wait", 32'(n),             32'd4);
    chk("halt_out",  bus.instr_out,      32'h05040302);
    chk("halt_pc",   32'(bus.instr_pc),  32'h0002);

    // Reset mid-word with a held output word.
    bus.instr_ready = 1'b0;
    repeat (2) step();
    chk("pre_rst_busy",  32'(bus.busy),        32'd1);
    chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),        32'd0);
    chk("mid_rst_addr",  32'(bus.mem_address), 32'h0000);
    chk("mid_rst_out",   bus.instr_out,        32'h0);
    chk("mid_rst_pc",    32'(bus.instr_pc),    32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
